// File: rtl/video_out_gen.sv
// Raster output stage: drains the video FIFO one pixel per active cycle and
// frames the stream with line_valid/frame_valid using fixed blanking intervals.
module video_out_gen #(
    parameter int P_WIDTH  = 640,
    parameter int P_HEIGHT = 480,
    parameter int H_BLANK  = 160,
    parameter int V_BLANK  = 40
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       en,
    input  logic       clr_err,
    input  logic       empty,
    input  logic [7:0] pixel_in,
    output logic       r_e,
    output logic [7:0] pixel_out,
    output logic       line_valid,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       underflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    localparam logic [9:0] H_ACT_LAST    = 10'(P_WIDTH - 1);
    localparam logic [9:0] H_BLANK_FIRST = 10'(P_WIDTH);
    localparam logic [9:0] H_LAST        = 10'(P_WIDTH + H_BLANK - 1);
    localparam logic [9:0] V_ACT_LAST    = 10'(P_HEIGHT - 1);
    localparam logic [9:0] V_LAST        = 10'(P_HEIGHT + V_BLANK - 1);

    state_t     state;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;

    assign h_wrap = (h_cnt == H_LAST);

    // Pop only in active slots with data present; an empty slot is skipped, not stalled.
    assign r_e = (state == ACTIVE) && !empty;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_out   <= '0;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clr_err) begin
                underflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    h_cnt       <= '0;
                    v_cnt       <= '0;
                    line_valid  <= 1'b0;
                    frame_valid <= 1'b0;
                    if (en && !empty) begin
                        state <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    // A starved slot still emits (as zero) so frame timing never slips.
                    pixel_out   <= empty ? 8'h00 : pixel_in;
                    line_valid  <= 1'b1;
                    frame_valid <= 1'b1;
                    if (empty) begin
                        underflow <= 1'b1;
                    end
                    h_cnt <= h_cnt + 10'd1;
                    if (h_cnt == H_ACT_LAST) begin
                        state <= HBLANK;
                    end
                end

                HBLANK: begin
                    line_valid <= 1'b0;
                    if (v_cnt == V_ACT_LAST) begin
                        frame_valid <= 1'b0;
                        if (h_cnt == H_BLANK_FIRST) begin
                            frame_done <= 1'b1;
                        end
                    end
                    if (h_wrap) begin
                        h_cnt <= '0;
                        v_cnt <= v_cnt + 10'd1;
                        state <= (v_cnt == V_ACT_LAST) ? VBLANK : ACTIVE;
                    end else begin
                        h_cnt <= h_cnt + 10'd1;
                    end
                end

                VBLANK: begin
                    line_valid  <= 1'b0;
                    frame_valid <= 1'b0;
                    if (h_wrap) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                            state <= IDLE;
                        end else begin
                            v_cnt <= v_cnt + 10'd1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 10'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_out_gen.sv
// Scoreboard bench for video_out_gen on a reduced raster: expected pixels and
// frame_done times are queued by the stimulus and consumed by a negedge monitor.
module tb_video_out_gen;

    localparam int PW = 8;
    localparam int PH = 4;
    localparam int HB = 3;
    localparam int VB = 2;
    localparam int L  = PW + HB;
    localparam int F  = PH + VB;

    logic       clk = 1'b0;
    logic       nRST;
    logic       en;
    logic       clr_err;
    logic       empty;
    logic [7:0] pixel_in;
    logic       r_e;
    logic [7:0] pixel_out;
    logic       line_valid;
    logic       frame_valid;
    logic       frame_done;
    logic       underflow;

    typedef struct {
        int         at;
        logic [7:0] px;
    } exp_t;

    exp_t exp_q[$];
    int   fd_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_byte = 0;
    int   fv_lo = 1;
    int   fv_hi = 0;
    bit   force_empty = 1'b1;
    logic [7:0] next_byte = 8'd0;

    always #5 clk = ~clk;

    video_out_gen #(
        .P_WIDTH (PW),
        .P_HEIGHT(PH),
        .H_BLANK (HB),
        .V_BLANK (VB)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .en         (en),
        .clr_err    (clr_err),
        .empty      (empty),
        .pixel_in   (pixel_in),
        .r_e        (r_e),
        .pixel_out  (pixel_out),
        .line_valid (line_valid),
        .frame_valid(frame_valid),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    // FIFO model: an endless byte ramp whose head advances on each pop.
    assign empty    = force_empty;
    assign pixel_in = force_empty ? 8'hA5 : next_byte;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r_e) next_byte <= next_byte + 8'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   fd_at;
        if (nRST === 1'b1) begin
            if (empty) checkOutput("r_e_while_empty", r_e, 0);
            checkOutput("frame_valid", frame_valid, (cyc >= fv_lo && cyc <= fv_hi));
            if (line_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pixel", line_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pixel_cycle", cyc, e.at);
                    checkOutput("pixel_value", pixel_out, e.px);
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) begin
                    checkOutput("unexpected_frame_done", frame_done, 0);
                end else begin
                    fd_at = fd_q.pop_front();
                    checkOutput("frame_done_cycle", cyc, fd_at);
                end
            end
        end
    end

    // Runs one frame from IDLE: uf_* starves the FIFO at a line/pixel, the *_at
    // arguments are slot indices (t) from the start edge, -1 disables them.
    task automatic applyStimulus(input int uf_line, input int uf_pix, input int uf_len,
                                 input int en_off_at, input int clr_at, input int rst_at,
                                 input logic exp_uf);
        int s;
        bit aborted;
        aborted     = 1'b0;
        en          = 1'b1;
        force_empty = 1'b0;
        s           = cyc + 1;
        fv_lo       = s + 1;
        fv_hi       = s + (PH - 1) * L + PW;
        for (int v = 0; v < PH; v++) begin
            for (int h = 0; h < PW; h++) begin
                if (v == uf_line && h >= uf_pix && h < uf_pix + uf_len) begin
                    exp_q.push_back('{s + v * L + h + 1, 8'h00});
                end else begin
                    exp_q.push_back('{s + v * L + h + 1, 8'(exp_byte)});
                    exp_byte++;
                end
            end
        end
        fd_q.push_back(s + (PH - 1) * L + PW + 1);

        for (int t = 0; t < L * F && !aborted; t++) begin
            tick;
            force_empty = (t / L == uf_line) && (t % L >= uf_pix) && (t % L < uf_pix + uf_len);
            clr_err     = (t == clr_at);
            if (t == en_off_at) en = 1'b0;
            if (t == rst_at) begin
                nRST = 1'b0;
                #1;
                checkOutput("rst_pixel_out", pixel_out, 0);
                checkOutput("rst_line_valid", line_valid, 0);
                checkOutput("rst_frame_valid", frame_valid, 0);
                checkOutput("rst_frame_done", frame_done, 0);
                checkOutput("rst_underflow", underflow, 0);
                checkOutput("rst_r_e", r_e, 0);
                exp_q.delete();
                fd_q.delete();
                fv_lo       = 1;
                fv_hi       = 0;
                clr_err     = 1'b0;
                force_empty = 1'b1;
                aborted     = 1'b1;
            end
        end

        if (!aborted) begin
            force_empty = 1'b0;
            clr_err     = 1'b0;
            tick;
            checkOutput("underflow_end", underflow, exp_uf);
        end
    endtask

    initial begin
        nRST    = 1'b0;
        en      = 1'b0;
        clr_err = 1'b0;
        tick;
        tick;
        checkOutput("reset_pixel_out", pixel_out, 0);
        checkOutput("reset_line_valid", line_valid, 0);
        checkOutput("reset_frame_valid", frame_valid, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_underflow", underflow, 0);
        checkOutput("reset_r_e", r_e, 0);

        nRST = 1'b1;
        tick;
        en = 1'b1;
        tick;
        tick;
        checkOutput("idle_empty_no_pop", r_e, 0);

        // Back-to-back frames: clean, starved at line 1, cleared, set/clear collision.
        applyStimulus(-1, 0, 0, -1, -1, -1, 1'b0);
        applyStimulus(1, 2, 3, -1, -1, -1, 1'b1);
        applyStimulus(-1, 0, 0, -1, 0, -1, 1'b0);
        applyStimulus(0, 3, 1, -1, 3, -1, 1'b1);
        // en drops during line 2; the frame must still finish, then stay idle.
        applyStimulus(-1, 0, 0, 22, 40, -1, 1'b0);
        repeat (8) begin
            tick;
            checkOutput("idle_en_off_no_pop", r_e, 0);
        end

        // Reset mid-frame at line 2 after an underflow has been flagged.
        applyStimulus(0, 1, 1, -1, -1, 26, 1'b0);
        tick;
        tick;
        nRST = 1'b1;
        repeat (3) begin
            tick;
            checkOutput("post_reset_idle", r_e, 0);
        end
        exp_byte = next_byte;
        applyStimulus(-1, 0, 0, -1, -1, -1, 1'b0);

        en = 1'b0;
        repeat (20) tick;
        checkOutput("leftover_pixels", exp_q.size(), 0);
        checkOutput("leftover_frame_done", fd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
